// File: rtl/register_file_reader.sv
// Read sequencer and drain FIFO for register_file: issues row reads, tracks the read latency, buffers rows.
// Define RF_READER_PERF_EN to build the stall_cycles performance counter (tied to 0 otherwise).
module register_file_reader #(
    parameter int MATRIX_WIDTH   = 14,
    parameter int REGISTER_DEPTH = 512,
    parameter int READ_LATENCY   = 7,
    parameter int FIFO_DEPTH     = 8,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = $clog2(REGISTER_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDR_W-1:0]                    cmd_base_addr,
    input  logic [15:0]                          cmd_length,
    input  logic                                 rf_enable,
    output logic [ADDR_W-1:0]                    rf_read_addr,
    input  logic [MATRIX_WIDTH-1:0][DATA_W-1:0]  rf_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MATRIX_WIDTH-1:0][DATA_W-1:0]  out_data,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic [31:0]                          stall_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int ROW_W = MATRIX_WIDTH * DATA_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W-1:0]       last_addr_q, last_addr_d;
    logic [15:0]             remain_q, remain_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    done_q, done_d;

    logic [ROW_W:0]          fifo_mem [FIFO_DEPTH];
    logic [ROW_W:0]          head;
    logic [INF_W-1:0]        inflight;
    logic                    issue, final_row, credit_ok, accept;
    logic                    push, pop, full, head_last;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(tag_vld_q[i]);
        end
    end

    // Credits cover both rows in the RAM pipe and rows already buffered, so a push never meets a full FIFO.
    assign credit_ok = (int'(inflight) + int'(count_q)) < FIFO_DEPTH;
    assign final_row = (remain_q == 16'd1);
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign done      = done_q;

    assign push      = tag_vld_q[READ_LATENCY-1] & rf_enable;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign head      = fifo_mem[rd_ptr_q];
    assign head_last = head[0];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? head[ROW_W:1] : '0;
    assign out_last  = out_valid & head_last;

    assign rf_read_addr = issue ? addr_q : last_addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        remain_d    = remain_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_base_addr;
                    remain_d = cmd_length;
                    if (cmd_length == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (rf_enable && credit_ok) begin
                    issue       = 1'b1;
                    last_addr_d = addr_q;
                    addr_d      = (addr_q == ADDR_W'(REGISTER_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                    remain_d    = remain_q - 16'd1;
                    if (final_row) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tags advance in lockstep with the register-file pipe, which is itself gated by rf_enable.
    always_comb begin
        tag_vld_d  = tag_vld_q;
        tag_last_d = tag_last_q;
        if (rf_enable) begin
            tag_vld_d  = (tag_vld_q << 1) | READ_LATENCY'(issue);
            tag_last_d = (tag_last_q << 1) | READ_LATENCY'(issue & final_row);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            remain_q    <= '0;
            tag_vld_q   <= '0;
            tag_last_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            remain_q    <= remain_d;
            tag_vld_q   <= tag_vld_d;
            tag_last_q  <= tag_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    // Row storage carries no reset; occupancy gating keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {rf_data, tag_last_q[READ_LATENCY-1]};
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

`ifdef RF_READER_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (((state_q == S_ISSUE) && !issue) || (out_valid && !out_ready)) begin
            if (stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_register_file_reader.sv
// Directed bench for register_file_reader with a behavioural 7-cycle register_file model.
module tb_register_file_reader;

    localparam int MW = 14;
    localparam int RD = 512;
    localparam int RL = 7;
    localparam int FD = 8;
    localparam int WW = 8;
    localparam int AW = 9;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [AW-1:0]           cmd_base_addr;
    logic [15:0]             cmd_length;
    logic                    rf_enable;
    logic [AW-1:0]           rf_read_addr;
    logic [MW-1:0][WW-1:0]   rf_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [MW-1:0][WW-1:0]   out_data;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic [31:0]             stall_cycles;

    register_file_reader #(
        .MATRIX_WIDTH  (MW),
        .REGISTER_DEPTH(RD),
        .READ_LATENCY  (RL),
        .FIFO_DEPTH    (FD),
        .DATA_W        (WW),
        .ADDR_W        (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base_addr(cmd_base_addr),
        .cmd_length   (cmd_length),
        .rf_enable    (rf_enable),
        .rf_read_addr (rf_read_addr),
        .rf_data      (rf_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Row content is a fixed function of the address so returned data identifies its source row.
    function automatic logic [MW-1:0][WW-1:0] row_of(input logic [AW-1:0] a);
        logic [MW-1:0][WW-1:0] r;
        logic [31:0] t;
        for (int k = 0; k < MW; k++) begin
            t = 32'(a) + 32'(k) * 32'd37;
            r[k] = t[WW-1:0];
        end
        return r;
    endfunction

    logic [AW-1:0] pipe [RL];
    always @(posedge clk) begin
        if (rf_enable) begin
            pipe[0] <= rf_read_addr;
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign rf_data = row_of(pipe[RL-1]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0]        addr_log [4096];
    int                   pop_cyc [$];
    logic [MW*WW-1:0]     pop_data [$];
    logic                 pop_last [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;

    always @(negedge clk) begin
        if (cyc < 4096) addr_log[cyc] <= rf_read_addr;
        if (out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (out_valid) valid_cnt <= valid_cnt + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int base, input int len, output int a);
        cmd_base_addr = AW'(base);
        cmd_length    = 16'(len);
        cmd_valid     = 1'b1;
        #1;
        chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        a = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int snap, input int budget);
        int n = 0;
        while (done_cnt == snap && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 128'(done_cnt != snap), 128'(1));
        repeat (3) tick();
        chk({nm, "_done_once"}, 128'(done_cnt - snap), 128'(1));
    endtask

    task automatic check_rows(input string nm, input int start, input int base, input int n, input int first_cyc);
        chk({nm, "_nrows"}, 128'(pop_data.size() - start), 128'(n));
        for (int i = 0; i < n; i++) begin
            if (start + i < pop_data.size()) begin
                logic [AW-1:0] ea;
                ea = AW'((base + i) % RD);
                chk($sformatf("%s_row%0d_data", nm, i), 128'(pop_data[start+i]), 128'(row_of(ea)));
                chk($sformatf("%s_row%0d_last", nm, i), 128'(pop_last[start+i]), 128'(i == n - 1));
                if (first_cyc >= 0)
                    chk($sformatf("%s_row%0d_cyc", nm, i), 128'(pop_cyc[start+i]), 128'(first_cyc + i));
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
        chk({nm, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({nm, "_out_last"},  128'(out_last),  128'(0));
        chk({nm, "_busy"},      128'(busy),      128'(0));
        chk({nm, "_done"},      128'(done),      128'(0));
        chk({nm, "_rd_addr"},   128'(rf_read_addr), 128'(0));
        chk({nm, "_out_data"},  128'(out_data),  128'(0));
        chk({nm, "_stall"},     128'(stall_cycles), 128'(0));
    endtask

    initial begin
        int a, sp, sd, sv, sb;
        cmd_valid = 1'b0; cmd_base_addr = '0; cmd_length = '0;
        rf_enable = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
        repeat (2) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic 4-row read with exact timing.
        sp = pop_data.size(); sd = done_cnt;
        send_cmd(10, 4, a);
        wait_done("t1", sd, 40);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_addr%0d", i), 128'(addr_log[a+1+i]), 128'(10 + i));
        chk("t1_addr_hold", 128'(addr_log[a+6]), 128'(13));
        check_rows("t1", sp, 10, 4, a + 9);
        chk("t1_done_cyc", 128'(done_cyc), 128'(a + 13));

        // Address wrap at REGISTER_DEPTH.
        sp = pop_data.size(); sd = done_cnt;
        send_cmd(510, 4, a);
        wait_done("t2", sd, 40);
        chk("t2_addr0", 128'(addr_log[a+1]), 128'(510));
        chk("t2_addr1", 128'(addr_log[a+2]), 128'(511));
        chk("t2_addr2", 128'(addr_log[a+3]), 128'(0));
        chk("t2_addr3", 128'(addr_log[a+4]), 128'(1));
        check_rows("t2", sp, 510, 4, a + 9);

        // Backpressure: credits cap outstanding reads at FIFO_DEPTH.
        sp = pop_data.size(); sd = done_cnt;
        out_ready = 1'b0;
        send_cmd(100, 20, a);
        repeat (29) tick();
        chk("t3_addr_8th", 128'(addr_log[a+8]), 128'(107));
        chk("t3_credit_stop", 128'(addr_log[a+29]), 128'(107));
        chk("t3_no_pop", 128'(pop_data.size() - sp), 128'(0));
        chk("t3_valid_held", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        wait_done("t3", sd, 120);
        check_rows("t3", sp, 100, 20, -1);
`ifdef RF_READER_PERF_EN
        chk("t3_stall_nonzero", 128'(stall_cycles != 32'd0), 128'(1));
`else
        chk("t3_stall_zero", 128'(stall_cycles), 128'(0));
`endif

        // Zero-length command.
        sp = pop_data.size(); sd = done_cnt; sv = valid_cnt; sb = busy_cnt;
        send_cmd(300, 0, a);
        wait_done("t4", sd, 10);
        chk("t4_done_cyc", 128'(done_cyc), 128'(a + 1));
        chk("t4_addr_a1", 128'(addr_log[a+1]), 128'(119));
        chk("t4_addr_a2", 128'(addr_log[a+2]), 128'(119));
        chk("t4_no_valid", 128'(valid_cnt - sv), 128'(0));
        chk("t4_no_busy", 128'(busy_cnt - sb), 128'(0));

        // rf_enable gap of 3 cycles during issue.
        sp = pop_data.size(); sd = done_cnt;
        send_cmd(200, 6, a);
        repeat (3) tick();
        rf_enable = 1'b0;
        repeat (3) tick();
        rf_enable = 1'b1;
        wait_done("t5", sd, 60);
        chk("t5_addr_gap", 128'(addr_log[a+5]), 128'(202));
        chk("t5_addr_resume", 128'(addr_log[a+7]), 128'(203));
        check_rows("t5", sp, 200, 6, a + 12);
        chk("t5_done_cyc", 128'(done_cyc), 128'(a + 18));

        // Reset in the middle of a command.
        sd = done_cnt;
        send_cmd(50, 10, a);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        sv = valid_cnt;
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        chk("t6_no_late_valid", 128'(valid_cnt - sv), 128'(0));
        chk("t6_no_done", 128'(done_cnt - sd), 128'(0));
        sp = pop_data.size(); sd = done_cnt;
        send_cmd(30, 3, a);
        wait_done("t6b", sd, 40);
        check_rows("t6b", sp, 30, 3, a + 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
